// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divider helper, receiver state encoding, frame constants.
// Also used by uart_transmitter so both ends derive identical bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  // Cycles per bit minus one; counters compare against this terminal value.
  function automatic int calc_baud_delay(input int comm_clk_frequency, input int baud_rate);
    return (comm_clk_frequency / baud_rate) - 1;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line in, received byte and status strobes out.
interface uart_receiver_if;
  logic       uart_rx;
  logic       tx_new_byte;
  logic [7:0] tx_byte;
  logic       framing_error;

  modport master (
    output uart_rx,
    input  tx_new_byte,
    input  tx_byte,
    input  framing_error
  );

  modport slave (
    input  uart_rx,
    output tx_new_byte,
    output tx_byte,
    output framing_error
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous level input; resets to 1 (idle-high lines).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling, false-start rejection and stop-bit check.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | confirming start bit at its centre
// DATA  | shifting in 8 data bits, LSB first
// STOP  | checking stop bit level
// BREAK | framing error seen, waiting for line to return high
module uart_receiver
  import uart_pkg::*;
#(
  parameter int comm_clk_frequency = 100000000,
  parameter int baud_rate          = 115200
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_receiver_if.slave rx_if
);

  localparam int          BAUD_DELAY_I = calc_baud_delay(comm_clk_frequency, baud_rate);
  localparam logic [15:0] baud_delay   = 16'(BAUD_DELAY_I);
  localparam logic [15:0] half_delay   = baud_delay / 16'd2;
  localparam logic [2:0]  LAST_BIT     = 3'(DATA_BITS - 1);

  generate
    if (BAUD_DELAY_I < 4 || BAUD_DELAY_I > 65534) begin : g_bad_baud
      $error("uart_receiver: baud_delay out of range (must be 4..65534)");
    end
  endgenerate

  logic rx_s;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(rx_if.uart_rx),
    .sync_o (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle after the centre; restarting at 1 keeps the bit period intact.
  localparam logic [15:0] START_PT = half_delay + 16'd1;
  localparam logic [15:0] BIT_PT   = baud_delay + 16'd1;
  localparam logic [15:0] CNT_RST  = 16'd1;

  logic [1:0] hist_q;
  logic       rx_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign rx_bit = majority3(hist_q[1], hist_q[0], rx_s);
`else
  localparam logic [15:0] START_PT = half_delay;
  localparam logic [15:0] BIT_PT   = baud_delay;
  localparam logic [15:0] CNT_RST  = 16'd0;

  logic rx_bit;

  assign rx_bit = rx_s;
`endif

  uart_state_e state_q;
  logic [15:0] delay_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  tx_byte_q;
  logic        tx_new_byte_q;
  logic        framing_error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      delay_cnt_q     <= 16'd0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      tx_byte_q       <= 8'h00;
      tx_new_byte_q   <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      tx_new_byte_q   <= 1'b0;
      framing_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          delay_cnt_q <= 16'd0;
          if (!rx_s) begin
            state_q <= START;
          end
        end
        START: begin
          if (delay_cnt_q == START_PT) begin
            delay_cnt_q <= CNT_RST;
            bit_idx_q   <= 3'd0;
            state_q     <= rx_bit ? IDLE : DATA;
          end else begin
            delay_cnt_q <= delay_cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (delay_cnt_q == BIT_PT) begin
            shift_q     <= {rx_bit, shift_q[7:1]};
            delay_cnt_q <= CNT_RST;
            bit_idx_q   <= bit_idx_q + 3'd1;
            if (bit_idx_q == LAST_BIT) begin
              state_q <= STOP;
            end
          end else begin
            delay_cnt_q <= delay_cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (delay_cnt_q == BIT_PT) begin
            delay_cnt_q <= 16'd0;
            if (rx_bit == STOP_LEVEL) begin
              tx_byte_q     <= shift_q;
              tx_new_byte_q <= 1'b1;
              state_q       <= IDLE;
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= BREAK;
            end
          end else begin
            delay_cnt_q <= delay_cnt_q + 16'd1;
          end
        end
        BREAK: begin
          // Only one error per low period; no frames are decoded until the line recovers.
          delay_cnt_q <= 16'd0;
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          delay_cnt_q <= 16'd0;
        end
      endcase
    end
  end

  assign rx_if.tx_byte       = tx_byte_q;
  assign rx_if.tx_new_byte   = tx_new_byte_q;
  assign rx_if.framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit (baud_delay = 15).
module tb_uart_receiver;

`ifdef UART_RX_MAJORITY_EN
  localparam int          LATENCY    = 156;
  localparam logic [7:0]  GLITCH_EXP = 8'hC3;
`else
  localparam int          LATENCY    = 155;
  localparam logic [7:0]  GLITCH_EXP = 8'hC7;
`endif

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  int         strobe_cnt;
  int         fe_cnt;
  int         strobe_cyc;
  logic [7:0] rx_q[$];

  uart_receiver_if bus ();

  uart_receiver #(
    .comm_clk_frequency(16),
    .baud_rate         (1)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    strobe_cnt = 0;
    fe_cnt     = 0;
    strobe_cyc = 0;
  end

  always @(negedge clk) begin
    if (bus.tx_new_byte === 1'b1) begin
      rx_q.push_back(bus.tx_byte);
      strobe_cyc = cyc;
      strobe_cnt++;
    end
    if (bus.framing_error === 1'b1) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives nseg clock-wide segments of a frame; segment glitch_seg is inverted.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_seg,
                            input int nseg);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int s = 0; s < nseg; s++) begin
      bus.uart_rx = fr[s / 16] ^ (s == glitch_seg);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line_level(input logic v, input int n);
    bus.uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int sb;
    int fb;
    int qb;
    int start_cyc;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.uart_rx = 1'b1;

    #3;
    check("reset_tx_byte", 32'(bus.tx_byte), 32'h00);
    check("reset_new_byte", 32'(bus.tx_new_byte), 32'h0);
    check("reset_framing", 32'(bus.framing_error), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    line_level(1'b1, 5);

    // Single frame A5 with latency check
    sb = strobe_cnt; fb = fe_cnt; qb = rx_q.size();
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, -1, 160);
    line_level(1'b1, 20);
    check("single_strobes", 32'(strobe_cnt - sb), 32'd1);
    check("single_byte", 32'(rx_q[qb]), 32'hA5);
    check("single_framing", 32'(fe_cnt - fb), 32'd0);
    check("single_latency", 32'(strobe_cyc - start_cyc), 32'(LATENCY));
    check("single_hold", 32'(bus.tx_byte), 32'hA5);

    // Back-to-back frames with zero idle time
    sb = strobe_cnt; fb = fe_cnt; qb = rx_q.size();
    send_frame(8'h00, 1'b1, -1, 160);
    send_frame(8'hFF, 1'b1, -1, 160);
    send_frame(8'h55, 1'b1, -1, 160);
    line_level(1'b1, 20);
    check("b2b_strobes", 32'(strobe_cnt - sb), 32'd3);
    check("b2b_byte0", 32'(rx_q[qb]), 32'h00);
    check("b2b_byte1", 32'(rx_q[qb + 1]), 32'hFF);
    check("b2b_byte2", 32'(rx_q[qb + 2]), 32'h55);
    check("b2b_framing", 32'(fe_cnt - fb), 32'd0);

    // False start rejected, then a valid frame
    sb = strobe_cnt; fb = fe_cnt; qb = rx_q.size();
    line_level(1'b0, 4);
    line_level(1'b1, 40);
    check("glitch_no_strobe", 32'(strobe_cnt - sb), 32'd0);
    check("glitch_no_framing", 32'(fe_cnt - fb), 32'd0);
    send_frame(8'h3C, 1'b1, -1, 160);
    line_level(1'b1, 20);
    check("glitch_next_strobes", 32'(strobe_cnt - sb), 32'd1);
    check("glitch_next_byte", 32'(rx_q[qb]), 32'h3C);

    // Stop bit low, then break held, then recovery
    sb = strobe_cnt; fb = fe_cnt; qb = rx_q.size();
    send_frame(8'h81, 1'b0, -1, 160);
    check("framing_pulse", 32'(fe_cnt - fb), 32'd1);
    check("framing_no_strobe", 32'(strobe_cnt - sb), 32'd0);
    check("framing_byte_kept", 32'(bus.tx_byte), 32'h3C);
    line_level(1'b0, 100);
    check("break_single_pulse", 32'(fe_cnt - fb), 32'd1);
    check("break_no_strobe", 32'(strobe_cnt - sb), 32'd0);
    line_level(1'b1, 20);
    send_frame(8'h42, 1'b1, -1, 160);
    line_level(1'b1, 20);
    check("recover_strobes", 32'(strobe_cnt - sb), 32'd1);
    check("recover_byte", 32'(rx_q[qb]), 32'h42);
    check("recover_framing", 32'(fe_cnt - fb), 32'd1);

    // Reset during bit 3 of F0
    sb = strobe_cnt; fb = fe_cnt; qb = rx_q.size();
    send_frame(8'hF0, 1'b1, -1, 70);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_byte", 32'(bus.tx_byte), 32'h00);
    check("midrst_new_byte", 32'(bus.tx_new_byte), 32'h0);
    check("midrst_framing", 32'(bus.framing_error), 32'h0);
    bus.uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    line_level(1'b1, 120);
    check("midrst_no_strobe", 32'(strobe_cnt - sb), 32'd0);
    check("midrst_no_framing", 32'(fe_cnt - fb), 32'd0);
    send_frame(8'h0F, 1'b1, -1, 160);
    line_level(1'b1, 20);
    check("postrst_strobes", 32'(strobe_cnt - sb), 32'd1);
    check("postrst_byte", 32'(rx_q[qb]), 32'h0F);

    // One-cycle glitch at the centre of data bit 2 (segment 16*3 + 8)
    sb = strobe_cnt; qb = rx_q.size();
    send_frame(8'hC3, 1'b1, 56, 160);
    line_level(1'b1, 20);
    check("midglitch_strobes", 32'(strobe_cnt - sb), 32'd1);
    check("midglitch_byte", 32'(rx_q[qb]), 32'(GLITCH_EXP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
